apb_master_param: RTL and testbench
===================================

APB_MASTER_PARAM -- requirements
Module: apb_master_param

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 8, meaning APB address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 8, meaning data width, a multiple of 8.
REQ-003 SHALL have parameter TIMEOUT_CYCLES, default 16, meaning maximum wait cycles in ACCESS (range 1..255).
REQ-004 SHALL have port pclk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 SHALL have port preset, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port transfer, input, 1 bit: user request valid.
REQ-007 SHALL have port read_write, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have ports apb_write_paddr and apb_read_paddr, input, ADDR_WIDTH each: write and read addresses.
REQ-009 SHALL have port apb_write_data, input, DATA_WIDTH: write data.
REQ-010 SHALL have port apb_write_strb, input, DATA_WIDTH/8: byte-lane write strobes.
REQ-011 SHALL have port req_ready, output, 1 bit: request accepted at this edge when transfer=1.
REQ-012 SHALL have port rsp_valid, output, 1 bit: one-cycle completion pulse.
REQ-013 SHALL have port rsp_err, output, 1 bit: completion error, qualified by rsp_valid.
REQ-014 SHALL have port apb_read_data_out, output, DATA_WIDTH: last read data.
REQ-015 SHALL have APB ports paddr (out, ADDR_WIDTH), psel, penable, pwrite (out, 1), pwdata (out, DATA_WIDTH), pstrb (out, DATA_WIDTH/8), pready, pslverr (in, 1), prdata (in, DATA_WIDTH).

Function
REQ-016 SHALL implement an FSM with states IDLE, SETUP and ACCESS.
REQ-017 SHALL drive req_ready=1 in IDLE, and in ACCESS when pready=1 or a timeout fires this cycle; otherwise 0.
REQ-018 SHALL accept a request at an edge where transfer=1 and req_ready=1, and go to SETUP.
REQ-019 SHALL latch at acceptance: pwrite=read_write, paddr=write or read address per read_write, pwdata, and pstrb=apb_write_strb for writes or all-zero for reads.
REQ-020 SHALL hold paddr, pwrite, pwdata and pstrb stable from SETUP through the end of ACCESS.
REQ-021 SHALL drive psel=1 and penable=0 in SETUP, then move unconditionally to ACCESS.
REQ-022 SHALL drive psel=1 and penable=1 in ACCESS, and stay in ACCESS while pready=0.
REQ-023 SHALL complete the transfer in ACCESS when pready=1: go to SETUP if a new request is accepted, otherwise to IDLE.
REQ-024 SHALL give minimum latency of acceptance edge N, SETUP cycle N+1, ACCESS cycle N+2, rsp_valid high in cycle N+3 when pready=1 at N+2.
REQ-025 SHALL, at the completion edge, register rsp_valid=1 for exactly one cycle with rsp_err=pslverr.
REQ-026 SHALL, on read completion, register apb_read_data_out=prdata, including when pslverr=1.
REQ-027 SHALL hold apb_read_data_out unchanged after write completions and between transfers.
REQ-028 SHALL drive psel=0 and penable=0 in IDLE.
REQ-029 SHALL ignore transfer when req_ready=0, so the user must hold transfer and payload until acceptance.
REQ-030 SHALL, on back-to-back transfers, return psel high through SETUP with penable=0 for one cycle between ACCESS phases.

Reset
REQ-031 SHALL, while preset=1 at a rising edge, enter IDLE regardless of state, including mid-ACCESS.
REQ-032 SHALL reset psel, penable, pwrite, rsp_valid and rsp_err to 0, and paddr, pwdata, pstrb and apb_read_data_out to all-zero.
REQ-033 SHALL clear the wait counter on reset, and SHALL produce no rsp_valid for a transfer aborted by reset.

Configuration
REQ-034 SHALL compile a wait-state timeout only when macro APB_MASTER_TIMEOUT_EN is defined.
REQ-035 SHALL, with APB_MASTER_TIMEOUT_EN defined, count consecutive ACCESS cycles with pready=0, clearing the count on entry to ACCESS.
REQ-036 SHALL, with APB_MASTER_TIMEOUT_EN defined and the count reaching TIMEOUT_CYCLES, abort with rsp_valid=1 and rsp_err=1, leave apb_read_data_out unchanged, and go to IDLE or SETUP per REQ-023.
REQ-037 SHALL, without APB_MASTER_TIMEOUT_EN, contain no counter and wait in ACCESS indefinitely.

Verification
REQ-038 SHALL verify single write: write to 0x10, data 0xA5, strb 1, pready=1 -> psel at N+1, penable at N+2, rsp_valid at N+3 with rsp_err=0.
REQ-039 SHALL verify read with waits: read 0x10, pready low 3 cycles, prdata=0xA5 -> ACCESS held 4 cycles, apb_read_data_out=0xA5, one rsp_valid pulse.
REQ-040 SHALL verify back-to-back: transfer held for write then read -> SETUP directly follows ACCESS with no IDLE cycle, and pstrb=0 on the read.
REQ-041 SHALL verify slave error: pslverr=1 with pready=1 on a read -> rsp_err=1 and apb_read_data_out updated.
REQ-042 SHALL verify reset mid-ACCESS: preset=1 while pready=0 -> next cycle IDLE with psel=0, penable=0, and no rsp_valid.
REQ-043 SHALL verify timeout: APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready stuck 0 -> abort after 4 wait cycles with rsp_err=1 and psel=0.

Source files
------------

// File: rtl/apb_master_param.sv
// APB master: accepts one user request at a time and runs it through SETUP/ACCESS.
// Optional wait-state timeout is compiled in with APB_MASTER_TIMEOUT_EN.
module apb_master_param #(
  parameter int ADDR_WIDTH     = 8,
  parameter int DATA_WIDTH     = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    pclk,
  input  logic                    preset,
  input  logic                    transfer,
  input  logic                    read_write,
  input  logic [ADDR_WIDTH-1:0]   apb_write_paddr,
  input  logic [ADDR_WIDTH-1:0]   apb_read_paddr,
  input  logic [DATA_WIDTH-1:0]   apb_write_data,
  input  logic [DATA_WIDTH/8-1:0] apb_write_strb,
  output logic                    req_ready,
  output logic                    rsp_valid,
  output logic                    rsp_err,
  output logic [DATA_WIDTH-1:0]   apb_read_data_out,
  output logic [ADDR_WIDTH-1:0]   paddr,
  output logic                    psel,
  output logic                    penable,
  output logic                    pwrite,
  output logic [DATA_WIDTH-1:0]   pwdata,
  output logic [DATA_WIDTH/8-1:0] pstrb,
  input  logic                    pready,
  input  logic                    pslverr,
  input  logic [DATA_WIDTH-1:0]   prdata
);

  localparam int STRB_WIDTH = DATA_WIDTH / 8;

  typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

  state_t state_reg, state_next;
  logic   timeout_fire;
  logic   done;
  logic   accept;

`ifdef APB_MASTER_TIMEOUT_EN
  logic [7:0] wait_cnt_reg;

  // ACCESS is only ever entered from SETUP, so clearing there resets the count on entry.
  always_ff @(posedge pclk) begin
    if (preset)
      wait_cnt_reg <= 8'd0;
    else if (state_reg == SETUP)
      wait_cnt_reg <= 8'd0;
    else if (state_reg == ACCESS && !pready)
      wait_cnt_reg <= wait_cnt_reg + 8'd1;
  end

  assign timeout_fire = (state_reg == ACCESS) && !pready &&
                        (wait_cnt_reg == 8'(TIMEOUT_CYCLES - 1));
`else
  assign timeout_fire = 1'b0;
`endif

  assign done   = (state_reg == ACCESS) && (pready || timeout_fire);
  assign accept = transfer && req_ready;

  always_ff @(posedge pclk) begin
    if (preset)
      state_reg <= IDLE;
    else
      state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    req_ready  = 1'b0;
    psel       = 1'b0;
    penable    = 1'b0;
    case (state_reg)
      IDLE: begin
        req_ready = 1'b1;
        if (transfer)
          state_next = SETUP;
      end
      SETUP: begin
        psel       = 1'b1;
        state_next = ACCESS;
      end
      ACCESS: begin
        psel      = 1'b1;
        penable   = 1'b1;
        req_ready = pready || timeout_fire;
        if (pready || timeout_fire)
          state_next = transfer ? SETUP : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge pclk) begin
    if (preset) begin
      paddr             <= '0;
      pwrite            <= 1'b0;
      pwdata            <= '0;
      pstrb             <= '0;
      rsp_valid         <= 1'b0;
      rsp_err           <= 1'b0;
      apb_read_data_out <= '0;
    end else begin
      rsp_valid <= done;
      rsp_err   <= done && (timeout_fire || pslverr);
      // A timed-out read has no valid prdata, so the last read value is kept.
      if (done && !pwrite && !timeout_fire)
        apb_read_data_out <= prdata;
      if (accept) begin
        pwrite <= read_write;
        paddr  <= read_write ? apb_write_paddr : apb_read_paddr;
        pwdata <= apb_write_data;
        pstrb  <= read_write ? apb_write_strb : {STRB_WIDTH{1'b0}};
      end
    end
  end

endmodule

// File: tb/tb_apb_master_param.sv
// Self-checking bench for apb_master_param: scenario tasks plus a response scoreboard.
// Define APB_MASTER_TIMEOUT_EN to exercise the timeout path instead of the indefinite wait.
module tb_apb_master_param;

  logic       pclk = 1'b0;
  logic       preset;
  logic       transfer;
  logic       read_write;
  logic [7:0] apb_write_paddr;
  logic [7:0] apb_read_paddr;
  logic [7:0] apb_write_data;
  logic [0:0] apb_write_strb;
  logic       req_ready;
  logic       rsp_valid;
  logic       rsp_err;
  logic [7:0] apb_read_data_out;
  logic [7:0] paddr;
  logic       psel;
  logic       penable;
  logic       pwrite;
  logic [7:0] pwdata;
  logic [0:0] pstrb;
  logic       pready;
  logic       pslverr;
  logic [7:0] prdata;

  typedef struct packed {
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t       sb[$];
  logic [7:0] exp_rd;
  int         checks = 0;
  int         errors = 0;

  always #5 pclk = ~pclk;

  apb_master_param #(
    .ADDR_WIDTH(8),
    .DATA_WIDTH(8),
    .TIMEOUT_CYCLES(4)
  ) dut (
    .pclk(pclk),
    .preset(preset),
    .transfer(transfer),
    .read_write(read_write),
    .apb_write_paddr(apb_write_paddr),
    .apb_read_paddr(apb_read_paddr),
    .apb_write_data(apb_write_data),
    .apb_write_strb(apb_write_strb),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid),
    .rsp_err(rsp_err),
    .apb_read_data_out(apb_read_data_out),
    .paddr(paddr),
    .psel(psel),
    .penable(penable),
    .pwrite(pwrite),
    .pwdata(pwdata),
    .pstrb(pstrb),
    .pready(pready),
    .pslverr(pslverr),
    .prdata(prdata)
  );

  // Scoreboard: every completion pulse is matched against the oldest expected response.
  always @(negedge pclk) begin
    exp_t e;
    if (preset === 1'b0 && rsp_valid === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL sb_unexpected_rsp got rsp_valid=1 err=%0b want no response", rsp_err);
      end else begin
        e = sb.pop_front();
        $display("rsp err=%0b data=%02h", rsp_err, apb_read_data_out);
        if ({rsp_err, apb_read_data_out} !== {e.err, e.data}) begin
          errors++;
          $display("FAIL sb_rsp got err=%0b data=%02h want err=%0b data=%02h",
                   rsp_err, apb_read_data_out, e.err, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic test_reset();
    preset = 1'b1; transfer = 1'b0; read_write = 1'b0;
    apb_write_paddr = '0; apb_read_paddr = '0; apb_write_data = '0; apb_write_strb = '0;
    pready = 1'b0; pslverr = 1'b0; prdata = '0;
    exp_rd = 8'h00;
    repeat (3) tick();
    checks++;
    if ({psel, penable, pwrite, rsp_valid, rsp_err} !== 5'b0) begin
      errors++;
      $display("FAIL reset_ctrl got %05b want 00000", {psel, penable, pwrite, rsp_valid, rsp_err});
    end
    checks++;
    if ({paddr, pwdata, pstrb, apb_read_data_out} !== 25'b0) begin
      errors++;
      $display("FAIL reset_data got paddr=%02h pwdata=%02h pstrb=%0b rd=%02h want zero",
               paddr, pwdata, pstrb, apb_read_data_out);
    end
    preset = 1'b0;
    tick();
    checks++;
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_req_ready got %0b want 1", req_ready);
    end
  endtask

  task automatic test_single_write();
    transfer = 1'b1; read_write = 1'b1;
    apb_write_paddr = 8'h10; apb_write_data = 8'hA5; apb_write_strb = 1'b1;
    pready = 1'b1;
    sb.push_back(exp_t'{err: 1'b0, data: exp_rd});
    tick();
    transfer = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pwdata, pstrb} !== {3'b101, 8'h10, 8'hA5, 1'b1}) begin
      errors++;
      $display("FAIL wr_setup got sel/en/wr=%03b addr=%02h wdata=%02h strb=%0b want 101 10 a5 1",
               {psel, penable, pwrite}, paddr, pwdata, pstrb);
    end
    tick();
    checks++;
    if ({psel, penable, req_ready, rsp_valid} !== 4'b1110) begin
      errors++;
      $display("FAIL wr_access got sel/en/rdy/vld=%04b want 1110", {psel, penable, req_ready, rsp_valid});
    end
    tick();
    checks++;
    if ({rsp_valid, psel, penable} !== 3'b100) begin
      errors++;
      $display("FAIL wr_done got vld/sel/en=%03b want 100", {rsp_valid, psel, penable});
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL wr_pulse got rsp_valid=%0b want 0", rsp_valid);
    end
  endtask

  task automatic test_read_waits();
    int access_cycles;
    transfer = 1'b1; read_write = 1'b0; apb_read_paddr = 8'h10;
    apb_write_strb = 1'b1; pready = 1'b0;
    sb.push_back(exp_t'{err: 1'b0, data: 8'hA5});
    exp_rd = 8'hA5;
    tick();
    transfer = 1'b0;
    checks++;
    if ({psel, penable, pwrite, paddr, pstrb} !== {3'b100, 8'h10, 1'b0}) begin
      errors++;
      $display("FAIL rd_setup got sel/en/wr=%03b addr=%02h strb=%0b want 100 10 0",
               {psel, penable, pwrite}, paddr, pstrb);
    end
    tick();
    access_cycles = 0;
    for (int i = 0; i < 3; i++) begin
      if (penable === 1'b1) access_cycles++;
      checks++;
      if ({req_ready, rsp_valid} !== 2'b00) begin
        errors++;
        $display("FAIL rd_wait%0d got rdy/vld=%02b want 00", i, {req_ready, rsp_valid});
      end
      tick();
    end
    pready = 1'b1; prdata = 8'hA5;
    if (penable === 1'b1) access_cycles++;
    tick();
    pready = 1'b0; prdata = 8'h00;
    checks++;
    if (access_cycles !== 4) begin
      errors++;
      $display("FAIL rd_access_len got %0d want 4", access_cycles);
    end
    checks++;
    if ({rsp_valid, psel} !== 2'b10) begin
      errors++;
      $display("FAIL rd_done got vld/sel=%02b want 10", {rsp_valid, psel});
    end
    tick();
    checks++;
    if (rsp_valid !== 1'b0) begin
      errors++;
      $display("FAIL rd_pulse got rsp_valid=%0b want 0", rsp_valid);
    end
  endtask

  task automatic test_back_to_back();
    transfer = 1'b1; read_write = 1'b1;
    apb_write_paddr = 8'h20; apb_write_data = 8'h3C; apb_write_strb = 1'b1;
    pready = 1'b1;
    sb.push_back(exp_t'{err: 1'b0, data: exp_rd});
    tick();
    read_write = 1'b0; apb_read_paddr = 8'h30;
    tick();
    checks++;
    if ({penable, req_ready, pwrite, paddr} !== {3'b111, 8'h20}) begin
      errors++;
      $display("FAIL b2b_wr_access got en/rdy/wr=%03b addr=%02h want 111 20",
               {penable, req_ready, pwrite}, paddr);
    end
    sb.push_back(exp_t'{err: 1'b0, data: 8'h5A});
    exp_rd = 8'h5A;
    tick();
    transfer = 1'b0; prdata = 8'h5A;
    checks++;
    if ({psel, penable, pwrite, pstrb, paddr, rsp_valid} !== {4'b1000, 8'h30, 1'b1}) begin
      errors++;
      $display("FAIL b2b_rd_setup got sel/en/wr/strb=%04b addr=%02h vld=%0b want 1000 30 1",
               {psel, penable, pwrite, pstrb}, paddr, rsp_valid);
    end
    tick();
    checks++;
    if ({psel, penable, rsp_valid} !== 3'b110) begin
      errors++;
      $display("FAIL b2b_rd_access got sel/en/vld=%03b want 110", {psel, penable, rsp_valid});
    end
    tick();
    checks++;
    if ({rsp_valid, psel} !== 2'b10) begin
      errors++;
      $display("FAIL b2b_rd_done got vld/sel=%02b want 10", {rsp_valid, psel});
    end
    prdata = 8'h00;
    tick();
  endtask

  task automatic test_slave_error();
    transfer = 1'b1; read_write = 1'b0; apb_read_paddr = 8'h44;
    pready = 1'b1; pslverr = 1'b1; prdata = 8'hE7;
    sb.push_back(exp_t'{err: 1'b1, data: 8'hE7});
    exp_rd = 8'hE7;
    tick();
    transfer = 1'b0;
    tick();
    tick();
    checks++;
    if ({rsp_valid, rsp_err, apb_read_data_out} !== {2'b11, 8'hE7}) begin
      errors++;
      $display("FAIL slverr got vld/err=%02b data=%02h want 11 e7",
               {rsp_valid, rsp_err}, apb_read_data_out);
    end
    pslverr = 1'b0; prdata = 8'h00;
    tick();
  endtask

  task automatic test_reset_mid_access();
    transfer = 1'b1; read_write = 1'b0; apb_read_paddr = 8'h55; pready = 1'b0;
    tick();
    transfer = 1'b0;
    tick();
    tick();
    checks++;
    if ({psel, penable} !== 2'b11) begin
      errors++;
      $display("FAIL rst_mid_pre got sel/en=%02b want 11", {psel, penable});
    end
    preset = 1'b1;
    tick();
    preset = 1'b0;
    exp_rd = 8'h00;
    checks++;
    if ({psel, penable, rsp_valid, apb_read_data_out} !== 11'b0) begin
      errors++;
      $display("FAIL rst_mid got sel/en/vld=%03b data=%02h want 000 00",
               {psel, penable, rsp_valid}, apb_read_data_out);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if ({rsp_valid, psel} !== 2'b00) begin
        errors++;
        $display("FAIL rst_mid_after%0d got vld/sel=%02b want 00", i, {rsp_valid, psel});
      end
    end
  endtask

`ifdef APB_MASTER_TIMEOUT_EN
  task automatic test_timeout();
    transfer = 1'b1; read_write = 1'b0; apb_read_paddr = 8'h77;
    pready = 1'b0; prdata = 8'h99;
    sb.push_back(exp_t'{err: 1'b1, data: exp_rd});
    tick();
    transfer = 1'b0;
    tick();
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({penable, rsp_valid, req_ready} !== {2'b10, (i == 3)}) begin
        errors++;
        $display("FAIL timeout_wait%0d got en/vld/rdy=%03b want 10%0b",
                 i, {penable, rsp_valid, req_ready}, (i == 3));
      end
      tick();
    end
    checks++;
    if ({rsp_valid, rsp_err, psel, penable} !== 4'b1100) begin
      errors++;
      $display("FAIL timeout_abort got vld/err/sel/en=%04b want 1100",
               {rsp_valid, rsp_err, psel, penable});
    end
    prdata = 8'h00;
    tick();
  endtask
`else
  task automatic test_no_timeout();
    transfer = 1'b1; read_write = 1'b1; apb_write_paddr = 8'h88;
    apb_write_data = 8'h11; pready = 1'b0;
    sb.push_back(exp_t'{err: 1'b0, data: exp_rd});
    tick();
    transfer = 1'b0;
    tick();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({psel, penable, rsp_valid} !== 3'b110) begin
        errors++;
        $display("FAIL nowait%0d got sel/en/vld=%03b want 110", i, {psel, penable, rsp_valid});
      end
      tick();
    end
    pready = 1'b1;
    tick();
    checks++;
    if ({rsp_valid, rsp_err} !== 2'b10) begin
      errors++;
      $display("FAIL nowait_done got vld/err=%02b want 10", {rsp_valid, rsp_err});
    end
    tick();
  endtask
`endif

  initial begin
    test_reset();
    test_single_write();
    test_read_waits();
    test_back_to_back();
    test_slave_error();
    test_reset_mid_access();
`ifdef APB_MASTER_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    tick();
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
